uart_rx_oversample: RTL and testbench
=====================================

// Module: uart_rx_oversample
// PURPOSE
//  UART receiver; other end of the TX path. Recovers 8N1 (optional parity) frames from serial rxd.
//  Sampling uses the 16x-baud square wave rx_clk from the baud generator, consumed as a sample-enable tick.
//  The whole block runs on clk (50 MHz) and never clocks logic on rx_clk.
//  Delivers bytes to the host-side logic over a valid/read handshake with error flags.
// PARAMETERS
//  DATA_BITS   8  payload bits per frame (5..8), LSB first
//  PARITY_EN   0  1 = parity bit follows data
//  PARITY_ODD  0  1 = odd parity, 0 = even (ignored when PARITY_EN=0)
// PORTS
//  clk          in   1          system clock, 50 MHz
//  reset_n      in   1          asynchronous, active-low reset
//  rx_tick_clk  in   1          16x-baud square wave from baud generator (async to logic use)
//  rxd          in   1          serial line, idle high, asynchronous
//  rx_read      in   1          1-cycle pulse: host consumed rx_data; clears rx_valid and flags
//  rx_data      out  DATA_BITS  last received payload, held until next completed frame
//  rx_valid     out  1          level: unread byte present
//  frame_err    out  1          stop bit sampled 0 for current rx_data
//  parity_err   out  1          parity mismatch for current rx_data (0 when PARITY_EN=0)
//  overrun_err  out  1          sticky: frame completed while rx_valid=1
//  rx_busy      out  1          1 whenever FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters 0; sync flops preset to 1 (rxd) / 0 (tick).
//  Reset is honoured mid-frame: partial frame discarded, no rx_valid.
//  Sync: rxd and rx_tick_clk each pass a 2-flop synchronizer.
//  tick = 1-cycle pulse on rising edge of the synced rx_tick_clk. All FSM updates qualify on tick.
//  Sample counter scnt 0..15 per bit. Samples taken at scnt 7,8,9. Bit value = majority of 3.
//  Decision is made at scnt==9.
//  FSM:
//   IDLE: on tick with rxd_s==0 and armed=1 -> START, scnt=0.
//         armed clears after frame_err and sets on first tick with rxd_s==1.
//   START: at scnt 9, majority=1 (glitch) -> IDLE, no output. Else continue; scnt 15 -> DATA.
//   DATA: at scnt 9 shift bit into shreg (LSB first). After DATA_BITS bits -> PARITY or STOP.
//   PARITY: at scnt 9 compute mismatch vs XOR(shreg)^PARITY_ODD. At scnt 15 -> STOP.
//   STOP: at scnt 9 complete the frame, then -> IDLE immediately. This allows start detection in
//         the remaining half bit, for resync.
//  Completion, registered, visible 1 clk after the scnt-9 tick of STOP:
//   if rx_valid==0: rx_data<=shreg; frame_err<=~stopbit; parity_err<=mismatch; rx_valid<=1.
//   if rx_valid==1: overrun_err<=1; rx_data/flags keep OLD values; new byte dropped.
//  rx_read: clears rx_valid, frame_err, parity_err, overrun_err next clk.
//  rx_read and completion in the same clk: completion wins. The new byte loads, rx_valid stays 1.
//   overrun_err is not set in this case.
//  rx_read while rx_valid=0: no effect.
//  Frame error does not abort the frame; data is still delivered, flagged.
// STRUCTURE
//  Shared package uart_pkg:
//   localparam OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9, SCNT_W=4
//   state encoding RX_IDLE/RX_START/RX_DATA/RX_PARITY/RX_STOP (3-bit, shared with TX)
//  Sub-module uart_sync_edge: 2-flop sync + previous-value flop. Outputs sync level and rise pulse.
//   Instanced twice: once for rx_tick_clk, once for rxd (level only).
//  Top: FSM, scnt, bit counter, 3-sample majority, shreg, output/flag registers.
// TESTING (baud generator instanced with baud_select=2'b11; tick per its rx_clk)
//  Send 0x55, then 0xA5, parity off, rx_read between -> rx_valid twice; rx_data 0x55 then 0xA5;
//   all flags 0.
//  Drive rxd low for 4 ticks, then high -> no START commit, rx_valid stays 0, rx_busy drops after
//   scnt 9.
//  Send 0x3C with stop bit = 0 -> rx_valid=1, rx_data=0x3C, frame_err=1. Hold line low:
//   no new frame until rxd high.
//  Send 0x11 then 0x22, no rx_read -> rx_data=0x11, overrun_err=1. rx_read clears all; next byte
//   is received normally.
//  PARITY_EN=1, PARITY_ODD=1: 0x07 with parity bit 1 -> parity_err=1; with parity bit 0 -> 0.
//  Assert reset_n low during DATA bit 4 of 0xFF; release, send 0x81 -> only 0x81 delivered,
//   flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART constants, FSM state encoding and helpers (RX/TX).
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;
  localparam int SCNT_W     = 4;

  // 3-bit encoding shared by the receive and transmit state machines
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // 2-of-3 vote used to reject single-sample noise on the line
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_edge
// Purpose  : Two-flop synchronizer for an asynchronous input, plus a
//            previous-value flop producing a one-cycle rising-edge pulse.
// Revision : 1.0  initial release
// ============================================================================
module uart_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Metastability chain followed by a history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {2{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversample.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_oversample
// Purpose  : 16x oversampling UART receiver (5..8 data bits, optional parity,
//            one stop bit). The baud tick is a synchronized square wave used
//            only as a sample enable; all logic runs on clk.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_tick_clk,
  input  logic                 rxd,
  input  logic                 rx_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int BCNT_W = 3;
  localparam logic [SCNT_W-1:0] SC_LO   = SCNT_W'(SAMPLE_LO);
  localparam logic [SCNT_W-1:0] SC_MID  = SCNT_W'(SAMPLE_MID);
  localparam logic [SCNT_W-1:0] SC_HI   = SCNT_W'(SAMPLE_HI);
  localparam logic [SCNT_W-1:0] SC_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BC_LAST = BCNT_W'(DATA_BITS - 1);
  localparam logic              ODD     = (PARITY_ODD != 0);
  localparam logic              PAR_ON  = (PARITY_EN != 0);

  logic tick;
  logic rxd_s;

  rx_state_e            state_q;
  logic [SCNT_W-1:0]    scnt_q;
  logic [BCNT_W-1:0]    bcnt_q;
  logic                 s_lo_q;
  logic                 s_mid_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 mismatch_q;
  logic                 armed_q;

  logic sample_maj;
  logic frame_done;

  uart_sync_edge #(.RESET_VAL(1'b0)) u_sync_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (rx_tick_clk),
    .level_o (),
    .rise_o  (tick)
  );

  uart_sync_edge #(.RESET_VAL(1'b1)) u_sync_rxd (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (rxd),
    .level_o (rxd_s),
    .rise_o  ()
  );

  // Third sample is taken live at the decision point, so vote with it directly
  assign sample_maj = maj3(s_lo_q, s_mid_q, rxd_s);
  assign frame_done = tick && (state_q == RX_STOP) && (scnt_q == SC_HI);
  assign rx_busy    = (state_q != RX_IDLE);

  // Receive FSM: sample counting, bit assembly, parity check and re-arm control
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RX_IDLE;
      scnt_q     <= '0;
      bcnt_q     <= '0;
      s_lo_q     <= 1'b0;
      s_mid_q    <= 1'b0;
      shreg_q    <= '0;
      mismatch_q <= 1'b0;
      armed_q    <= 1'b0;
    end else if (tick) begin
      if (scnt_q == SC_LO)  s_lo_q  <= rxd_s;
      if (scnt_q == SC_MID) s_mid_q <= rxd_s;
      scnt_q <= scnt_q + 1'b1;
      case (state_q)
        RX_IDLE: begin
          // The detecting tick counts as sample 0 of the start bit
          scnt_q <= '0;
          if (rxd_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q    <= RX_START;
            mismatch_q <= 1'b0;
          end
        end
        RX_START: begin
          if ((scnt_q == SC_HI) && sample_maj) begin
            state_q <= RX_IDLE;
            scnt_q  <= '0;
          end else if (scnt_q == SC_LAST) begin
            state_q <= RX_DATA;
            bcnt_q  <= '0;
          end
        end
        RX_DATA: begin
          if (scnt_q == SC_HI) shreg_q <= {sample_maj, shreg_q[DATA_BITS-1:1]};
          if (scnt_q == SC_LAST) begin
            if (bcnt_q == BC_LAST) state_q <= PAR_ON ? RX_PARITY : RX_STOP;
            else                   bcnt_q  <= bcnt_q + 1'b1;
          end
        end
        RX_PARITY: begin
          if (scnt_q == SC_HI)   mismatch_q <= sample_maj ^ (^shreg_q) ^ ODD;
          if (scnt_q == SC_LAST) state_q    <= RX_STOP;
        end
        RX_STOP: begin
          // Leave half a bit early so a following start edge is not missed;
          // a low stop bit means a break/stuck line, so wait for idle first
          if (scnt_q == SC_HI) begin
            state_q <= RX_IDLE;
            scnt_q  <= '0;
            if (!sample_maj) armed_q <= 1'b0;
          end
        end
        default: begin
          state_q <= RX_IDLE;
          scnt_q  <= '0;
        end
      endcase
    end
  end

  // Host interface: load on completion unless an unread byte would be lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else if (frame_done && (!rx_valid || rx_read)) begin
      rx_data     <= shreg_q;
      frame_err   <= ~sample_maj;
      parity_err  <= PAR_ON & mismatch_q;
      rx_valid    <= 1'b1;
      overrun_err <= 1'b0;
    end else if (frame_done) begin
      overrun_err <= 1'b1;
    end else if (rx_read) begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversample.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_oversample
// Purpose  : Self-checking bench for uart_rx_oversample (8N1 and 8O1 units).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_tick_clk = 1'b0;
  logic       rxd = 1'b1;
  logic       rxd_p = 1'b1;
  logic       rx_read = 1'b0;
  logic       rx_read_p = 1'b0;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, frame_err, parity_err, overrun_err, rx_busy;
  logic       rx_valid_p, frame_err_p, parity_err_p, overrun_err_p, rx_busy_p;

  // 50 MHz system clock; 16x baud square wave of 8 clk periods
  always #10 clk = ~clk;
  always #80 rx_tick_clk = ~rx_tick_clk;

  uart_rx_oversample #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .rx_tick_clk(rx_tick_clk), .rxd(rxd),
    .rx_read(rx_read), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err),
    .overrun_err(overrun_err), .rx_busy(rx_busy)
  );

  uart_rx_oversample #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_p (
    .clk(clk), .reset_n(reset_n), .rx_tick_clk(rx_tick_clk), .rxd(rxd_p),
    .rx_read(rx_read_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p),
    .overrun_err(overrun_err_p), .rx_busy(rx_busy_p)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    bit         which;
    logic [7:0] data;
    bit         pbit;
    bit         stop;
    logic [7:0] exp_data;
    bit         exp_fe;
    bit         exp_pe;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_line(input bit which, input logic v);
    if (which) rxd_p = v;
    else       rxd   = v;
  endtask

  task automatic bit_time(input bit which, input logic v, input int ticks);
    drive_line(which, v);
    repeat (ticks) @(posedge rx_tick_clk);
  endtask

  // Line is left at the stop-bit level on return
  task automatic send_frame(input bit which, input logic [7:0] d, input bit pbit, input bit stop);
    @(posedge rx_tick_clk);
    bit_time(which, 1'b0, 16);
    for (int i = 0; i < 8; i++) bit_time(which, d[i], 16);
    if (which) bit_time(which, pbit, 16);
    bit_time(which, stop, 16);
  endtask

  task automatic pulse_read(input bit which);
    @(negedge clk);
    if (which) rx_read_p = 1'b1; else rx_read = 1'b1;
    @(negedge clk);
    rx_read_p = 1'b0;
    rx_read   = 1'b0;
    @(negedge clk);
  endtask

  // Wait (bounded) for a byte, then compare it with the scoreboard head
  task automatic expect_byte(input bit which, input string name, input bit exp_ovr);
    int   cyc;
    exp_t e;
    cyc = 0;
    @(negedge clk);
    while (((which ? rx_valid_p : rx_valid) == 1'b0) && (cyc < 4000)) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_valid"}, which ? rx_valid_p : rx_valid, 1'b1);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_sb actual=empty required=entry", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_data"}, which ? rx_data_p : rx_data, e.data);
      chk({name, "_fe"}, which ? frame_err_p : frame_err, e.fe);
      chk({name, "_pe"}, which ? parity_err_p : parity_err, e.pe);
      chk({name, "_ovr"}, which ? overrun_err_p : overrun_err, exp_ovr);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // which, data, parity bit, stop, expected data, fe, pe
    vecs[0] = '{1'b0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1};

    // Reset state
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_fe", frame_err, 1'b0);
    chk("rst_pe", parity_err, 1'b0);
    chk("rst_ovr", overrun_err, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_valid_p", rx_valid_p, 1'b0);
    repeat (32) @(posedge rx_tick_clk);

    // Table-driven frames with read between each
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back('{vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_pe});
      send_frame(vecs[i].which, vecs[i].data, vecs[i].pbit, vecs[i].stop);
      expect_byte(vecs[i].which, $sformatf("vec%0d", i), 1'b0);
      pulse_read(vecs[i].which);
      chk($sformatf("vec%0d_rd_valid", i), vecs[i].which ? rx_valid_p : rx_valid, 1'b0);
      chk($sformatf("vec%0d_rd_fe", i), vecs[i].which ? frame_err_p : frame_err, 1'b0);
      drive_line(vecs[i].which, 1'b1);
      repeat (32) @(posedge rx_tick_clk);
    end

    // Short low glitch: start rejected at the vote, nothing delivered
    @(posedge rx_tick_clk);
    rxd = 1'b0;
    repeat (4) @(posedge rx_tick_clk);
    rxd = 1'b1;
    @(negedge clk);
    chk("glitch_busy_hi", rx_busy, 1'b1);
    repeat (12) @(posedge rx_tick_clk);
    @(negedge clk);
    chk("glitch_busy_lo", rx_busy, 1'b0);
    chk("glitch_valid", rx_valid, 1'b0);
    repeat (16) @(posedge rx_tick_clk);

    // Frame error, then line held low: no new frame until it returns high
    sb_q.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    expect_byte(1'b0, "ferr", 1'b0);
    repeat (40) @(posedge rx_tick_clk);
    @(negedge clk);
    chk("hold_low_busy", rx_busy, 1'b0);
    chk("hold_low_ovr", overrun_err, 1'b0);
    pulse_read(1'b0);
    repeat (40) @(posedge rx_tick_clk);
    @(negedge clk);
    chk("hold_low_valid", rx_valid, 1'b0);
    chk("hold_low_busy2", rx_busy, 1'b0);
    rxd = 1'b1;
    repeat (32) @(posedge rx_tick_clk);
    sb_q.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
    expect_byte(1'b0, "after_break", 1'b0);
    pulse_read(1'b0);
    repeat (16) @(posedge rx_tick_clk);

    // Overrun: second byte dropped, first kept, sticky flag set
    sb_q.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(1'b0, 8'h11, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1);
    expect_byte(1'b0, "ovr", 1'b1);
    pulse_read(1'b0);
    chk("ovr_clr_valid", rx_valid, 1'b0);
    chk("ovr_clr_ovr", overrun_err, 1'b0);
    repeat (16) @(posedge rx_tick_clk);
    sb_q.push_back('{8'h33, 1'b0, 1'b0});
    send_frame(1'b0, 8'h33, 1'b0, 1'b1);
    expect_byte(1'b0, "post_ovr", 1'b0);
    pulse_read(1'b0);
    repeat (16) @(posedge rx_tick_clk);

    // Reset during data bit 4 of 0xFF: partial frame discarded
    @(posedge rx_tick_clk);
    bit_time(1'b0, 1'b0, 16);
    for (int i = 0; i < 4; i++) bit_time(1'b0, 1'b1, 16);
    bit_time(1'b0, 1'b1, 8);
    @(negedge clk);
    chk("midrst_busy_before", rx_busy, 1'b1);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy", rx_busy, 1'b0);
    chk("midrst_valid", rx_valid, 1'b0);
    reset_n = 1'b1;
    repeat (8 + 3 * 16 + 16) @(posedge rx_tick_clk);
    @(negedge clk);
    chk("midrst_no_valid", rx_valid, 1'b0);
    sb_q.push_back('{8'h81, 1'b0, 1'b0});
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    expect_byte(1'b0, "post_rst", 1'b0);
    pulse_read(1'b0);

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
